// File: rtl/dmem_req_ctrl.sv
// Data-memory request controller: registers a load/store from the memory
// stage, holds it on the D-cache port until the response, stalls the pipeline
// meanwhile, then holds the returned word until the instruction leaves MEM.
module dmem_req_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_read,
    input  logic             req_write,
    input  logic [3:0]       req_mbe,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic             ext_stall,
    output logic             mem_stall,
    output logic [31:0]      rdata_out,
    output logic             dcache_read,
    output logic             dcache_write,
    output logic [3:0]       dcache_mbe,
    output logic [31:0]      dcache_address,
    output logic [31:0]      dcache_wdata,
    input  logic [31:0]      dcache_rdata,
    input  logic             dcache_resp,
    output logic [CNT_W-1:0] load_count,
    output logic [CNT_W-1:0] store_count,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [3:0]  mbe_q;
    logic        req_any;

    // Stall is raised in the very cycle a request is seen, then for the whole access
    assign req_any   = req_read | req_write;
    assign mem_stall = (state == BUSY) || ((state == IDLE) && req_any);

    // Cache port is driven only from the request registers
    assign dcache_address = addr_q;
    assign dcache_wdata   = wdata_q;
    assign dcache_mbe     = mbe_q;
    assign rdata_out      = rdata_q;

    // Controller state, request registers, strobes and performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            mbe_q        <= '0;
            dcache_read  <= 1'b0;
            dcache_write <= 1'b0;
            load_count   <= '0;
            store_count  <= '0;
            stall_cycles <= '0;
        end else begin
            if (mem_stall) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (req_any) begin
                        // A simultaneous read and write request is issued as a write
                        addr_q       <= req_addr;
                        wdata_q      <= req_wdata;
                        mbe_q        <= req_write ? req_mbe : 4'hF;
                        dcache_read  <= ~req_write;
                        dcache_write <= req_write;
                        state        <= BUSY;
                    end
                end
                BUSY: begin
                    if (dcache_resp) begin
                        dcache_read  <= 1'b0;
                        dcache_write <= 1'b0;
                        if (dcache_write) begin
                            store_count <= store_count + CNT_W'(1);
                        end else begin
                            rdata_q    <= dcache_rdata;
                            load_count <= load_count + CNT_W'(1);
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Same instruction still requests while frozen; never reissue it
                    if (!ext_stall) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    dcache_read  <= 1'b0;
                    dcache_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Self-checking bench for dmem_req_ctrl: directed scenarios plus randomized
// load/store traffic checked against a transaction-level reference model.
module tb_dmem_req_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_read;
    logic        req_write;
    logic [3:0]  req_mbe;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        ext_stall;
    logic        mem_stall;
    logic [31:0] rdata_out;
    logic        dcache_read;
    logic        dcache_write;
    logic [3:0]  dcache_mbe;
    logic [31:0] dcache_address;
    logic [31:0] dcache_wdata;
    logic [31:0] dcache_rdata;
    logic        dcache_resp;
    logic [31:0] load_count;
    logic [31:0] store_count;
    logic [31:0] stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: expected counters and held load word
    logic [31:0] exp_load;
    logic [31:0] exp_store;
    logic [31:0] exp_stall;
    logic [31:0] exp_rdata;

    always #5 clk = ~clk;

    dmem_req_ctrl #(.CNT_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_read       (req_read),
        .req_write      (req_write),
        .req_mbe        (req_mbe),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .ext_stall      (ext_stall),
        .mem_stall      (mem_stall),
        .rdata_out      (rdata_out),
        .dcache_read    (dcache_read),
        .dcache_write   (dcache_write),
        .dcache_mbe     (dcache_mbe),
        .dcache_address (dcache_address),
        .dcache_wdata   (dcache_wdata),
        .dcache_rdata   (dcache_rdata),
        .dcache_resp    (dcache_resp),
        .load_count     (load_count),
        .store_count    (store_count),
        .stall_cycles   (stall_cycles)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_stall"}, 32'(mem_stall), 32'd0);
        check_eq({tag, "_rd"}, 32'(dcache_read), 32'd0);
        check_eq({tag, "_wr"}, 32'(dcache_write), 32'd0);
        check_eq({tag, "_rdata"}, rdata_out, exp_rdata);
        check_eq({tag, "_loads"}, load_count, exp_load);
        check_eq({tag, "_stores"}, store_count, exp_store);
        check_eq({tag, "_stallcnt"}, stall_cycles, exp_stall);
    endtask

    task automatic idle_inputs();
        req_read    = 1'b0;
        req_write   = 1'b0;
        ext_stall   = 1'b0;
        dcache_resp = 1'b0;
    endtask

    // One memory instruction: request in cycle 0, response in cycle resp_cyc,
    // then ext_cyc frozen DONE cycles with the request still held.
    task automatic do_op(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [3:0] mbe, input logic [31:0] wdata,
                         input int resp_cyc, input int ext_cyc, input logic [31:0] rdata);
        bit          is_wr;
        logic [3:0]  exp_mbe;
        is_wr   = wr;
        exp_mbe = is_wr ? mbe : 4'hF;
        tick();
        req_read    = rd;
        req_write   = wr;
        req_addr    = addr;
        req_mbe     = mbe;
        req_wdata   = wdata;
        ext_stall   = 1'b0;
        dcache_resp = 1'b0;
        #1;
        check_eq("req_stall_c0", 32'(mem_stall), 32'd1);
        check_eq("req_nostrobe_c0", 32'({dcache_read, dcache_write}), 32'd0);
        for (int c = 1; c <= resp_cyc; c++) begin
            tick();
            // Upstream churn while busy must not reach the cache port
            req_wdata    = (c == 1) ? 32'hFFFF_FFFF : $urandom;
            req_addr     = 32'($urandom) & 32'hFFFF_FFFC;
            req_mbe      = 4'($urandom);
            ext_stall    = 1'($urandom);
            dcache_resp  = (c == resp_cyc);
            dcache_rdata = (c == resp_cyc) ? rdata : $urandom;
            #1;
            check_eq("busy_stall", 32'(mem_stall), 32'd1);
            check_eq("busy_rd", 32'(dcache_read), 32'(!is_wr));
            check_eq("busy_wr", 32'(dcache_write), 32'(is_wr));
            check_eq("busy_addr", dcache_address, addr);
            check_eq("busy_mbe", 32'(dcache_mbe), 32'(exp_mbe));
            check_eq("busy_wdata", dcache_wdata, wdata);
        end
        exp_stall = exp_stall + 32'(resp_cyc + 1);
        if (is_wr) begin
            exp_store = exp_store + 32'd1;
        end else begin
            exp_load  = exp_load + 32'd1;
            exp_rdata = rdata;
        end
        for (int k = 0; k <= ext_cyc; k++) begin
            tick();
            dcache_resp  = 1'b0;
            dcache_rdata = $urandom;
            req_read     = rd;
            req_write    = wr;
            ext_stall    = (k < ext_cyc);
            #1;
            check_quiet("done");
        end
    endtask

    task automatic idle_cycle(input bit stray_resp);
        tick();
        idle_inputs();
        ext_stall    = 1'($urandom);
        dcache_resp  = stray_resp;
        dcache_rdata = $urandom;
        #1;
        check_quiet("idle");
    endtask

    initial begin
        rst          = 1'b1;
        idle_inputs();
        req_mbe      = '0;
        req_addr     = '0;
        req_wdata    = '0;
        dcache_rdata = '0;
        exp_load     = '0;
        exp_store    = '0;
        exp_stall    = '0;
        exp_rdata    = '0;
        tick();
        tick();
        check_quiet("reset");
        check_eq("reset_addr", dcache_address, 32'd0);
        check_eq("reset_mbe", 32'(dcache_mbe), 32'd0);
        rst = 1'b0;
        idle_cycle(1'b0);

        // Directed scenarios
        do_op(1'b1, 1'b0, 32'h0000_0100, 4'h0, 32'h0, 3, 0, 32'hDEAD_BEEF);
        check_eq("tp_load_count", load_count, 32'd1);
        check_eq("tp_stall_cycles", stall_cycles, 32'd4);
        do_op(1'b0, 1'b1, 32'h0000_0200, 4'b0100, 32'h00AB_0000, 2, 0, 32'h1234_5678);
        check_eq("tp_store_rdata", rdata_out, 32'hDEAD_BEEF);
        do_op(1'b1, 1'b0, 32'h0000_0300, 4'h0, 32'h0, 1, 3, 32'hCAFE_F00D);
        do_op(1'b1, 1'b0, 32'h0000_0400, 4'h0, 32'h0, 2, 0, 32'h0000_0011);
        do_op(1'b1, 1'b0, 32'h0000_0404, 4'h0, 32'h0, 1, 0, 32'h0000_0022);
        do_op(1'b1, 1'b1, 32'h0000_0500, 4'b1010, 32'h5555_AAAA, 1, 1, 32'h9999_9999);
        idle_cycle(1'b1);

        // Reset while an access is outstanding; late response is ignored
        tick();
        req_read  = 1'b1;
        req_addr  = 32'h0000_0600;
        #1;
        tick();
        check_eq("rst_busy_rd", 32'(dcache_read), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        exp_load  = '0;
        exp_store = '0;
        exp_stall = '0;
        exp_rdata = '0;
        #1;
        check_quiet("after_rst");
        dcache_resp  = 1'b1;
        dcache_rdata = 32'hBAD0_BAD0;
        tick();
        dcache_resp = 1'b0;
        #1;
        check_quiet("late_resp");

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            bit rd;
            bit wr;
            int sel;
            sel = int'($urandom_range(0, 9));
            rd  = (sel < 5) || (sel == 9);
            wr  = (sel >= 5);
            do_op(rd, wr, 32'($urandom) & 32'hFFFF_FFFC, 4'($urandom), $urandom,
                  int'($urandom_range(1, 5)), int'($urandom_range(0, 3)), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                idle_cycle(1'($urandom));
            end
        end
        idle_cycle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_req_ctrl.md
# dmem_req_ctrl

Data-memory request controller between the pipeline memory stage and the L1 data cache. It registers the read/write request the memory stage produces and holds it stable on the cache port until `dcache_resp`. It stalls the pipeline while the access is outstanding, then holds the returned word for the memory stage until the pipeline advances. It also keeps load/store/stall-cycle performance counters.

## Interface
- `CNT_W`, default 32: width of each performance counter.
- `clk` in 1: pipeline clock.
- `rst` in 1: reset; synchronous, active-high.
- `req_read` in 1: memory stage requests a load; level, held while the instruction sits in MEM.
- `req_write` in 1: memory stage requests a store; level.
- `req_mbe` in 4: store byte enables.
- `req_addr` in 32: word-aligned address (`[1:0]` always 0).
- `req_wdata` in 32: store data.
- `ext_stall` in 1: pipeline frozen by another source (e.g. I-cache miss); MEM instruction does not advance this cycle.
- `mem_stall` out 1: freeze pipeline; data access outstanding.
- `rdata_out` out 32: load word returned to the memory stage (its `data_rdata`).
- `dcache_read` out 1: cache read strobe.
- `dcache_write` out 1: cache write strobe.
- `dcache_mbe` out 4: cache byte enables.
- `dcache_address` out 32: cache address.
- `dcache_wdata` out 32: cache write data.
- `dcache_rdata` in 32: cache read data; valid with `dcache_resp`.
- `dcache_resp` in 1: one-cycle completion pulse.
- `load_count` out CNT_W: completed loads.
- `store_count` out CNT_W: completed stores.
- `stall_cycles` out CNT_W: cycles with `mem_stall` high.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE, no request: no change.
  - `mem_stall`=0.
  - Strobes low.
- IDLE with `req_read|req_write` = 1:
  - `mem_stall`=1 combinationally in that cycle.
  - Latch addr, mbe, wdata and op into request registers.
  - Go to BUSY.
  - If `req_read` and `req_write` are both 1, the request is treated as a write.
- BUSY:
  - Drive `dcache_*` from the request registers only. Upstream changes are ignored.
  - Exactly one strobe is high; `dcache_mbe` = 4'b1111 for reads.
  - `mem_stall`=1.
  - On `dcache_resp`: for a load, capture `dcache_rdata` into the rdata register. Increment `load_count` or `store_count`. Go to DONE.
- DONE:
  - Strobes low; `mem_stall`=0.
  - `rdata_out` holds the captured word.
  - If `ext_stall`=1: stay in DONE. Do not reissue, even though `req_*` is still asserted by the same instruction.
  - If `ext_stall`=0: the instruction leaves MEM at this edge; go to IDLE.
- `rdata_out` = rdata register in all states. Stores do not update it.
- `dcache_resp` outside BUSY is ignored: no capture, no count.
- `stall_cycles` increments every cycle `mem_stall`=1, including the IDLE request-detect cycle.
- All counters wrap modulo 2^CNT_W.
- Reset in any state:
  - FSM goes to IDLE.
  - Strobes low, registers and counters 0.
  - Any outstanding cache transaction is abandoned; the cache shares `rst`.

## Timing
- Reset values: all outputs 0; `mem_stall` 0 unless a request is present in IDLE.
- Request seen in cycle 0 → strobes asserted from cycle 1.
- `dcache_resp` arriving in cycle N ≥ 1 → DONE in cycle N+1, `rdata_out` valid in N+1, strobes low in N+1.
- Minimum occupancy per memory op is 3 cycles: IDLE, BUSY, DONE.
- `mem_stall` is high cycles 0..N and low from N+1.
- Back-to-back ops: DONE→IDLE, and the next instruction's request is detected in that IDLE cycle.
- Strobes never stay high after the `dcache_resp` cycle.
- Request registers are stable from cycle 1 through N.
- `ext_stall` has no effect in IDLE and BUSY.

## Test plan
- Load, addr 0x100, resp in cycle 3 with rdata 0xDEADBEEF:
  - `dcache_read` high in cycles 1–3.
  - `mem_stall` high in cycles 0–3.
  - `rdata_out`=0xDEADBEEF from cycle 4.
  - `load_count`=1, `stall_cycles`=4.
- Store, mbe 4'b0100, wdata 0x00AB0000:
  - `dcache_write` carries mbe 0100 and unchanged wdata.
  - Upstream wdata changed to 0xFFFFFFFF mid-BUSY does not appear on `dcache_wdata`.
  - `store_count`=1; `rdata_out` unchanged.
- `ext_stall`=1 for 3 cycles after resp:
  - FSM stays in DONE.
  - No second strobe; `rdata_out` held.
  - `load_count` stays 1.
- Two consecutive loads (resp 0x11, then 0x22): two distinct requests; `rdata_out` 0x11 then 0x22; `load_count`=2.
- `rst` asserted in BUSY:
  - Next cycle IDLE, strobes 0, counters 0.
  - A late `dcache_resp` pulse is ignored.
- Stray `dcache_resp` in IDLE: no state change, `rdata_out` and counters unchanged.
